julia_render_sched: RTL and testbench
=====================================

# julia_render_sched

Frame-render scheduler for the Julia fractal datapath. Walks a downsampled pixel grid, issues one complex-plane coordinate per pixel to the iteration engine over a start/done handshake, and writes each returned iteration count into the frame-buffer BRAM that the HDMI pixel path reads. Also owns the Julia constant c: it updates c from the user buttons and re-renders only at a vertical-sync boundary. It sits between the button/timing inputs of `gfx` and the `julia_bram_crtl` engine and BRAM.

## Interface
- `GRID_W`, 320: render columns
- `GRID_H`, 180: render rows
- `X_MIN`, -8192: Q4.12 real coordinate of column 0 (-2.0)
- `Y_MIN`, -4608: Q4.12 imaginary coordinate of row 0 (-1.125)
- `STEP`, 51: Q4.12 per-pixel increment, both axes
- `C_RE_INIT`, -3277: reset value of c real (-0.8)
- `C_IM_INIT`, 639: reset value of c imag (0.156)
- `C_STEP`, 41: Q4.12 button increment (~0.01)
- `clk` in 1: pixel clock
- `rst` in 1: asynchronous, active-low reset
- `i_v_sync` in 1: vertical sync from timing generator
- `i_btn` in 3: raw buttons; [0] c_re+, [1] c_im+, [2] restore c defaults
- `o_eng_start` out 1: one-cycle pulse, engine launch
- `o_eng_cx`, `o_eng_cy` out 16 signed: Q4.12 pixel coordinate, held from start until done
- `o_eng_c_re`, `o_eng_c_im` out 16 signed: frame-locked c
- `i_eng_done` in 1: one-cycle pulse, result valid
- `i_eng_iter` in 8: iteration count, valid with done
- `o_wr_en` out 1: BRAM write strobe
- `o_wr_addr` out 16: `row*GRID_W+col`
- `o_wr_data` out 8: iteration count
- `o_busy` out 1: high from frame start through the last write
- `o_frame_done` out 1: one-cycle pulse after the last write
- `o_frame_cnt` out 16: completed frames, wraps at 65535 to 0

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, WRITE, DONE.
- IDLE:
  - Detect the `i_v_sync` rising edge on a registered copy.
  - On that edge, if `dirty` is set: latch pending c into the frame c, clear `dirty`, set col=row=addr=0, set cx=`X_MIN` and cy=`Y_MIN`, then go to ISSUE.
  - Otherwise stay in IDLE. The image stays static.
- ISSUE: assert `o_eng_start` for one cycle, then go to WAIT_DONE.
- WAIT_DONE: wait for `i_eng_done`. Capture `i_eng_iter`, then go to WRITE.
  - `i_eng_done` in any other state is ignored.
- WRITE:
  - Assert `o_wr_en` for one cycle.
  - Advance: col++ and cx+=STEP. At col=GRID_W-1, set col=0, cx=X_MIN, row++, cy+=STEP. Increment addr.
  - Last pixel (row=GRID_H-1, col=GRID_W-1): go to DONE. Otherwise go to ISSUE.
- DONE: pulse `o_frame_done`, increment `o_frame_cnt`, go to IDLE.
- Button handling:
  - Each button passes through a 2-FF synchronizer and rising-edge detect.
  - btn0: pending c_re += C_STEP. btn1: pending c_im += C_STEP.
  - When a result exceeds +8192 it wraps to -8192.
  - btn2: pending c = init values.
  - Any button edge sets `dirty`.
  - Buttons during a render update only the pending c. The frame c stays constant for the whole frame.
  - Simultaneous edges: btn2 wins; btn0 and btn1 otherwise both apply.
- A vsync edge while not in IDLE is dropped, not queued.
- Coordinates are built by accumulation, never multiplied. 16-bit signed; the default parameters cannot overflow.

## Timing
- Reset values:
  - All strobes 0; addr, data, cx, cy, and frame_cnt 0.
  - Pending and frame c = init values.
  - `dirty`=1, so the first vsync after reset renders.
- `o_eng_start` goes high 1 cycle after the qualifying vsync edge is registered.
- Per pixel: 1 cycle ISSUE, then engine latency, then 1 cycle after done for `o_wr_en`, then the next `o_eng_start` in the following cycle.
- Write address and data are registered and valid in the same cycle as `o_wr_en`.
- Reset asserted mid-frame: immediate return to IDLE, all outputs at reset values, and no further writes. The partially written BRAM is re-rendered on the next vsync.

## Configuration
- `JULIA_AUTO_ANIM_EN` defined:
  - Each completed frame adds C_STEP to pending c_im, using the same wrap rule, and sets `dirty`.
  - Every vsync that arrives while IDLE therefore renders a new frame.
- `JULIA_AUTO_ANIM_EN` undefined: renders only after reset or a button edge.

## Structure
- Package `julia_pkg`: Q4.12 format width, default X_MIN/Y_MIN/STEP/C constants, C_LIMIT (8192), FSM state enum.
- Sub-module `julia_btn_edge`: per-bit 2-FF synchronizer plus rising-edge pulse, parameterized width. Instantiated once for `i_btn`.

## Test plan
- Reset with no vsync: all outputs 0, `o_eng_c_re`=-3277, `o_eng_c_im`=639.
- First vsync, engine model responds 3 cycles after start with iter=addr[7:0]:
  - 57600 writes, addr 0..57599.
  - cx: pixel0 -8192, pixel1 -8141, pixel 319 8077.
  - cy: pixel 320 -4557, last pixel 4521.
  - One `o_frame_done` pulse; `o_frame_cnt`=1.
- Second vsync with no button press: no `o_eng_start`; `o_busy` stays 0.
- btn0 pulse mid-frame:
  - Current frame keeps c_re=-3277.
  - Next vsync renders with c_re=-3236.
  - btn0+btn2 in the same cycle: c returns to the init values.
- Vsync during render is dropped: frame completes once; no restart.
- Reset asserted at pixel 1000: `o_wr_en` is 0 from that cycle on. The next vsync after release restarts at addr 0.

Source files
------------

// File: rtl/julia_pkg.sv
// Shared Q4.12 constants, state encoding and the c-update wrap helper for the
// Julia frame-render scheduler.
package julia_pkg;

  localparam int Q_W    = 16;
  localparam int FRAC_W = 12;

  localparam logic signed [15:0] X_MIN_DEF     = -16'sd8192;
  localparam logic signed [15:0] Y_MIN_DEF     = -16'sd4608;
  localparam logic signed [15:0] STEP_DEF      = 16'sd51;
  localparam logic signed [15:0] C_RE_INIT_DEF = -16'sd3277;
  localparam logic signed [15:0] C_IM_INIT_DEF = 16'sd639;
  localparam logic signed [15:0] C_STEP_DEF    = 16'sd41;
  localparam logic signed [16:0] C_LIMIT       = 17'sd8192;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_WRITE     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Adds step to a c component; anything above +C_LIMIT snaps to -C_LIMIT.
  function automatic logic signed [15:0] c_add_wrap(input logic signed [15:0] v,
                                                    input logic signed [15:0] step);
    logic signed [16:0] sum;
    logic signed [16:0] neg_lim;
    sum     = {v[15], v} + {step[15], step};
    neg_lim = -C_LIMIT;
    if (sum > C_LIMIT) return neg_lim[15:0];
    else               return sum[15:0];
  endfunction

endpackage

// File: rtl/julia_btn_edge.sv
// Per-bit two-flop synchronizer followed by a one-cycle rising-edge pulse.
module julia_btn_edge #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/julia_render_sched.sv
// Julia frame-render scheduler: walks the pixel grid, drives the iteration engine
// and writes counts to the frame buffer. Optional macro: JULIA_AUTO_ANIM_EN.
module julia_render_sched
  import julia_pkg::*;
#(
  parameter int                GRID_W    = 320,
  parameter int                GRID_H    = 180,
  parameter logic signed [15:0] X_MIN     = X_MIN_DEF,
  parameter logic signed [15:0] Y_MIN     = Y_MIN_DEF,
  parameter logic signed [15:0] STEP      = STEP_DEF,
  parameter logic signed [15:0] C_RE_INIT = C_RE_INIT_DEF,
  parameter logic signed [15:0] C_IM_INIT = C_IM_INIT_DEF,
  parameter logic signed [15:0] C_STEP    = C_STEP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_v_sync,
  input  logic [2:0]         i_btn,
  output logic               o_eng_start,
  output logic signed [15:0] o_eng_cx,
  output logic signed [15:0] o_eng_cy,
  output logic signed [15:0] o_eng_c_re,
  output logic signed [15:0] o_eng_c_im,
  input  logic               i_eng_done,
  input  logic [7:0]         i_eng_iter,
  output logic               o_wr_en,
  output logic [15:0]        o_wr_addr,
  output logic [7:0]         o_wr_data,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic [15:0]        o_frame_cnt,
  output logic [2:0]         o_state
);

  localparam logic [15:0] COL_LAST = 16'(GRID_W - 1);
  localparam logic [15:0] ROW_LAST = 16'(GRID_H - 1);

  // Engine handshake: o_eng_start is a one-cycle launch; cx/cy/c stay stable
  // until i_eng_done, a one-cycle pulse qualifying i_eng_iter. done outside
  // WAIT_DONE is ignored; there is no back-pressure on either side.

  state_t state, state_n;

  logic               vs_q, vs_qq;
  logic               dirty, dirty_n;
  logic signed [15:0] pend_re, pend_re_n;
  logic signed [15:0] pend_im, pend_im_n;
  logic signed [15:0] frame_re, frame_im;
  logic signed [15:0] cx, cy;
  logic [15:0]        col, row, addr;
  logic [7:0]         wr_data;
  logic [15:0]        frame_cnt;
  logic [2:0]         btn_rise;
  logic               frame_go;
  logic               last_px;

  julia_btn_edge #(.W(3)) u_btn_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (i_btn),
    .rise (btn_rise)
  );

  assign frame_go = (state == ST_IDLE) && vs_q && !vs_qq && dirty;
  assign last_px  = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:      if (frame_go) state_n = ST_ISSUE;
      ST_ISSUE:     state_n = ST_WAIT_DONE;
      ST_WAIT_DONE: if (i_eng_done) state_n = ST_WRITE;
      ST_WRITE:     state_n = last_px ? ST_DONE : ST_ISSUE;
      ST_DONE:      state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  // Pending c follows the buttons at any time; the frame copy only moves at frame start.
  always_comb begin
    pend_re_n = pend_re;
    pend_im_n = pend_im;
    dirty_n   = dirty;
    if (frame_go) dirty_n = 1'b0;
    if (btn_rise[2]) begin
      pend_re_n = C_RE_INIT;
      pend_im_n = C_IM_INIT;
    end else begin
      if (btn_rise[0]) pend_re_n = c_add_wrap(pend_re, C_STEP);
      if (btn_rise[1]) pend_im_n = c_add_wrap(pend_im, C_STEP);
    end
`ifdef JULIA_AUTO_ANIM_EN
    if (state == ST_DONE) begin
      if (!btn_rise[2]) pend_im_n = c_add_wrap(pend_im_n, C_STEP);
      dirty_n = 1'b1;
    end
`endif
    if (|btn_rise) dirty_n = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q      <= 1'b0;
      vs_qq     <= 1'b0;
      dirty     <= 1'b1;
      pend_re   <= C_RE_INIT;
      pend_im   <= C_IM_INIT;
      frame_re  <= C_RE_INIT;
      frame_im  <= C_IM_INIT;
      cx        <= '0;
      cy        <= '0;
      col       <= '0;
      row       <= '0;
      addr      <= '0;
      wr_data   <= '0;
      frame_cnt <= '0;
    end else begin
      vs_q    <= i_v_sync;
      vs_qq   <= vs_q;
      dirty   <= dirty_n;
      pend_re <= pend_re_n;
      pend_im <= pend_im_n;
      case (state)
        ST_IDLE: begin
          if (frame_go) begin
            frame_re <= pend_re;
            frame_im <= pend_im;
            col      <= '0;
            row      <= '0;
            addr     <= '0;
            cx       <= X_MIN;
            cy       <= Y_MIN;
          end
        end
        ST_WAIT_DONE: if (i_eng_done) wr_data <= i_eng_iter;
        ST_WRITE: begin
          addr <= addr + 16'd1;
          if (col == COL_LAST) begin
            col <= '0;
            cx  <= X_MIN;
            row <= row + 16'd1;
            cy  <= cy + STEP;
          end else begin
            col <= col + 16'd1;
            cx  <= cx + STEP;
          end
        end
        ST_DONE: frame_cnt <= frame_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  assign o_eng_start  = (state == ST_ISSUE);
  assign o_wr_en      = (state == ST_WRITE);
  assign o_frame_done = (state == ST_DONE);
  assign o_busy       = (state == ST_ISSUE) || (state == ST_WAIT_DONE) || (state == ST_WRITE);
  assign o_eng_cx     = cx;
  assign o_eng_cy     = cy;
  assign o_eng_c_re   = frame_re;
  assign o_eng_c_im   = frame_im;
  assign o_wr_addr    = addr;
  assign o_wr_data    = wr_data;
  assign o_frame_cnt  = frame_cnt;
  assign o_state      = state;

endmodule

// File: tb/tb_julia_render_sched.sv
// Directed bench for julia_render_sched on a reduced 8x4 grid with a 3-cycle
// engine responder and a write scoreboard.
module tb_julia_render_sched;

  localparam int GW = 8;
  localparam int GH = 4;
  localparam int NPX = GW * GH;

  logic               clk;
  logic               rst;
  logic               i_v_sync;
  logic [2:0]         i_btn;
  logic               o_eng_start;
  logic signed [15:0] o_eng_cx, o_eng_cy, o_eng_c_re, o_eng_c_im;
  logic               i_eng_done;
  logic [7:0]         i_eng_iter;
  logic               o_wr_en;
  logic [15:0]        o_wr_addr;
  logic [7:0]         o_wr_data;
  logic               o_busy, o_frame_done;
  logic [15:0]        o_frame_cnt;
  logic [2:0]         o_state;

  julia_render_sched #(.GRID_W(GW), .GRID_H(GH)) dut (
    .clk(clk), .rst(rst), .i_v_sync(i_v_sync), .i_btn(i_btn),
    .o_eng_start(o_eng_start), .o_eng_cx(o_eng_cx), .o_eng_cy(o_eng_cy),
    .o_eng_c_re(o_eng_c_re), .o_eng_c_im(o_eng_c_im),
    .i_eng_done(i_eng_done), .i_eng_iter(i_eng_iter),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt),
    .o_state(o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // logs filled by the monitor, indexed by position within the current frame
  int         st_total = 0, wr_total = 0, done_total = 0, busy_total = 0;
  int         st_base = 0, wr_base = 0;
  int         cx_log[64], cy_log[64], cre_log[64], cim_log[64];
  int         addr_log[64], data_log[64];
  logic [8:0] expd_log[64];
  logic [7:0] exp_q[$];

  // engine responder + monitor, all at the falling edge
  initial begin
    int cnt;
    int eng_n;
    int k;
    cnt = 0;
    eng_n = 0;
    i_eng_done = 1'b0;
    i_eng_iter = 8'h00;
    forever begin
      @(negedge clk);
      if (o_wr_en) begin
        k = (wr_total - wr_base) & 63;
        addr_log[k] = int'(o_wr_addr);
        data_log[k] = int'(o_wr_data);
        if (exp_q.size() > 0) expd_log[k] = {1'b0, exp_q.pop_front()};
        else                  expd_log[k] = 9'h100;
        wr_total++;
      end
      if (o_busy) busy_total++;
      if (!rst) begin
        cnt = 0;
        i_eng_done = 1'b0;
        exp_q.delete();
      end else begin
        if (o_eng_start) begin
          k = (st_total - st_base) & 63;
          cx_log[k]  = int'(o_eng_cx);
          cy_log[k]  = int'(o_eng_cy);
          cre_log[k] = int'(o_eng_c_re);
          cim_log[k] = int'(o_eng_c_im);
          st_total++;
        end
        if (o_frame_done) done_total++;
        i_eng_done = 1'b0;
        if (cnt != 0) begin
          cnt--;
          if (cnt == 0) begin
            i_eng_done = 1'b1;
            i_eng_iter = 8'(eng_n * 37 + 5);
            exp_q.push_back(i_eng_iter);
            eng_n++;
          end
        end
        if (o_eng_start) cnt = 3;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic vsync_pulse();
    i_v_sync = 1'b1;
    repeat (3) @(negedge clk);
    i_v_sync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] mask);
    i_btn = mask;
    repeat (4) @(negedge clk);
    i_btn = 3'b000;
    repeat (4) @(negedge clk);
  endtask

  task automatic mark_frame();
    st_base = st_total;
    wr_base = wr_total;
  endtask

  task automatic wait_frame(input string nm);
    int n;
    n = 0;
    while (!o_frame_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_frame_done_seen"}, int'(o_frame_done), 1);
    @(negedge clk);
  endtask

  task automatic wait_writes(input int w);
    int n;
    n = 0;
    while ((wr_total - wr_base) < w && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_writes_reached", int'((wr_total - wr_base) >= w), 1);
  endtask

  task automatic check_frame(input string nm, input int cre, input int cim);
    chk({nm, "_writes"}, wr_total - wr_base, NPX);
    chk({nm, "_starts"}, st_total - st_base, NPX);
    for (int k = 0; k < NPX; k++) begin
      chk($sformatf("%s_addr%0d", nm, k), addr_log[k], k);
      chk($sformatf("%s_data%0d", nm, k), data_log[k], int'(expd_log[k]));
      chk($sformatf("%s_cx%0d", nm, k), cx_log[k], -8192 + (k % GW) * 51);
      chk($sformatf("%s_cy%0d", nm, k), cy_log[k], -4608 + (k / GW) * 51);
      chk($sformatf("%s_cre%0d", nm, k), cre_log[k], cre);
      chk($sformatf("%s_cim%0d", nm, k), cim_log[k], cim);
    end
  endtask

  initial begin
    int snap_st, snap_busy, snap_done, snap_wr;
    rst = 1'b0;
    i_v_sync = 1'b0;
    i_btn = 3'b000;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_eng_start", int'(o_eng_start), 0);
    chk("rst_wr_en", int'(o_wr_en), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_frame_done", int'(o_frame_done), 0);
    chk("rst_frame_cnt", int'(o_frame_cnt), 0);
    chk("rst_wr_addr", int'(o_wr_addr), 0);
    chk("rst_wr_data", int'(o_wr_data), 0);
    chk("rst_cx", int'(o_eng_cx), 0);
    chk("rst_cy", int'(o_eng_cy), 0);
    chk("rst_c_re", int'(o_eng_c_re), -3277);
    chk("rst_c_im", int'(o_eng_c_im), 639);
    chk("rst_state", int'(o_state), 0);

    rst = 1'b1;
    repeat (3) @(negedge clk);

    // frame 1 from the reset-dirty flag
    mark_frame();
    vsync_pulse();
    wait_frame("f1");
    check_frame("f1", -3277, 639);
    chk("f1_frame_cnt", int'(o_frame_cnt), 1);
    chk("f1_cx_px1", cx_log[1], -8141);
    chk("f1_cx_px7", cx_log[7], -7835);
    chk("f1_cy_px8", cy_log[8], -4557);
    chk("f1_cy_last", cy_log[NPX-1], -4455);
    chk("f1_done_pulses", done_total, 1);

    // clean vsync without a button: image stays static
    snap_st = st_total;
    snap_busy = busy_total;
    vsync_pulse();
    repeat (40) @(negedge clk);
    chk("idle_no_start", st_total, snap_st);
    chk("idle_no_busy", busy_total, snap_busy);

    // frame 2: btn0 and a vsync arrive mid-render
    press(3'b100);
    mark_frame();
    snap_done = done_total;
    vsync_pulse();
    wait_writes(10);
    press(3'b001);
    vsync_pulse();
    wait_frame("f2");
    check_frame("f2", -3277, 639);
    chk("f2_frame_cnt", int'(o_frame_cnt), 2);
    chk("f2_done_once", done_total - snap_done, 1);
    snap_st = st_total;
    repeat (60) @(negedge clk);
    chk("f2_vsync_dropped", st_total, snap_st);

    // frame 3 picks up the mid-frame btn0
    mark_frame();
    vsync_pulse();
    wait_frame("f3");
    check_frame("f3", -3236, 639);
    chk("f3_frame_cnt", int'(o_frame_cnt), 3);

    // btn0 and btn2 together: restore wins
    press(3'b101);
    mark_frame();
    vsync_pulse();
    wait_frame("f4");
    check_frame("f4", -3277, 639);

    // c_im up to just below the limit, then across it
    for (int i = 0; i < 184; i++) press(3'b010);
    mark_frame();
    vsync_pulse();
    wait_frame("f5");
    check_frame("f5", -3277, 8183);
    press(3'b010);
    mark_frame();
    vsync_pulse();
    wait_frame("f6");
    check_frame("f6", -3277, -8192);
    chk("f6_frame_cnt", int'(o_frame_cnt), 6);

    // reset in the middle of a frame
    press(3'b001);
    mark_frame();
    vsync_pulse();
    wait_writes(20);
    rst = 1'b0;
    #1;
    chk("mrst_wr_en", int'(o_wr_en), 0);
    chk("mrst_busy", int'(o_busy), 0);
    chk("mrst_frame_cnt", int'(o_frame_cnt), 0);
    chk("mrst_wr_addr", int'(o_wr_addr), 0);
    chk("mrst_c_re", int'(o_eng_c_re), -3277);
    snap_wr = wr_total;
    repeat (20) @(negedge clk);
    chk("mrst_no_writes", wr_total, snap_wr);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    mark_frame();
    vsync_pulse();
    wait_frame("f7");
    check_frame("f7", -3277, 639);
    chk("f7_frame_cnt", int'(o_frame_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
